sdram_usb_packetizer: RTL and testbench
=======================================

// Module: sdram_usb_packetizer
// PURPOSE
//  Upload stage between the SDRAM read FIFO and the USB stream-in FIFO (FPGA->PC).
//  After a start pulse it drains exactly total_words samples from the read FIFO.
//  It writes them into the USB FIFO as framed packets: header, sequence, length, payload.
//  Runs in the clk50m domain. Frames let the host resynchronise and detect lost packets.
// PARAMETERS
//  PKT_WORDS  256       max payload words per packet, 1..4095
//  HDR_WORD   16'hA55A  first word of every packet
//  FIFO_DEPTH 2048      USB FIFO depth in words
//  USEDW_W    11        width of usb_fifo_usedw
// PORTS
//  clk             in  1        clk50m; everything is on rising edge
//  reset           in  1        asynchronous, active-high
//  start           in  1        1-cycle pulse, begins an upload; ignored while busy=1
//  total_words     in  32       words to upload; sampled on the accepted start
//  rdfifo_empty    in  1        SDRAM read FIFO empty
//  rdfifo_rden     out 1        read strobe; rdfifo_dout is valid 1 cycle later (normal mode)
//  rdfifo_dout     in  16       read FIFO data
//  usb_fifo_usedw  in  USEDW_W  USB FIFO fill level
//  usb_fifo_wrreq  out 1        USB FIFO write strobe
//  usb_fifo_wrdata out 16       USB FIFO write data
//  busy            out 1        high from the accepted start until done
//  done            out 1        1-cycle pulse when the last word of the upload is written
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs 0; sequence counter 0; remaining counter 0.
//  - States: IDLE -> WAIT_SPACE -> HDR0 -> HDR1 -> HDR2 -> PAYLOAD [-> TRAILER] -> WAIT_SPACE | FIN -> IDLE.
//  - IDLE: on start, latch remaining = total_words and set busy.
//    - If total_words == 0: go to FIN, so done pulses 2 cycles after start with no writes.
//    - Otherwise go to WAIT_SPACE.
//  - WAIT_SPACE: compute len = min(remaining, PKT_WORDS) and hold it in a register.
//    - Advance only when usb_fifo_usedw <= FIFO_DEPTH - (len + OVH) - 8.
//    - OVH = 3, or 4 with the trailer. The 8-word margin covers usedw latency.
//  - HDR0, HDR1, HDR2: one write per cycle with wrreq=1.
//    - HDR0 writes HDR_WORD. HDR1 writes seq[15:0]. HDR2 writes {4'b0, len[11:0]}.
//  - PAYLOAD: rden=1 when !rdfifo_empty and issued < len.
//    - Each rden produces wrreq=1 with wrdata=rdfifo_dout exactly 1 cycle later.
//    - An empty read FIFO only stalls reads. No word is dropped or duplicated.
//    - PAYLOAD ends when the len-th payload word is written.
//  - End of packet: seq increments and wraps 16'hFFFF -> 0. remaining -= len.
//    - If remaining != 0, return to WAIT_SPACE; else go to FIN.
//  - FIN: done=1 for 1 cycle, busy=0 in the same cycle, then IDLE.
//  - seq resets to 0 only on reset. It is not cleared by start, so the host sees continuity across uploads.
//  - Last packet: len = remainder when total_words is not a multiple of PKT_WORDS. Never padded.
//  - wrreq is never asserted in IDLE, WAIT_SPACE or FIN.
//  - rden is never asserted outside PAYLOAD and never more than len times per packet.
//  - Reset mid-operation: immediate abort. No further rden or wrreq. Partial packet is left in the USB FIFO.
//  - start coincident with FIN: ignored; a new start is needed after done.
// CONFIGURATION
//  UPLOAD_CHECKSUM_EN defined:
//    - A TRAILER state follows PAYLOAD and writes one word: the 16-bit wrapping sum of the packet's payload words.
//    - The sum is cleared in HDR0. OVH = 4.
//  UPLOAD_CHECKSUM_EN undefined: no TRAILER state, OVH = 3, no adder logic.
// TESTING
//  1. PKT_WORDS=256, total=600, incrementing data, no stalls, usedw=0
//     -> 3 packets with len 256,256,88 and seq 0,1,2; 609 writes; one done pulse.
//  2. total=0 -> no rden, no wrreq; done pulses 2 cycles after start; busy high for those cycles.
//  3. total=10, read FIFO empty toggles every other cycle
//     -> payload is exactly 10 words in order; each wrreq lands 1 cycle after its rden.
//  4. usedw forced to 1900 during WAIT_SPACE -> no writes; release to 100 -> HDR0 the next cycle.
//  5. Reset asserted after 40 payload words -> rden and wrreq low immediately.
//     A new upload after reset starts with seq=0.
//  6. UPLOAD_CHECKSUM_EN, total=4, data 16'hFFFF x4 -> trailer 16'hFFFC after the payload; 8 writes total.

Source files
------------

// File: rtl/sdram_usb_packetizer.sv
// Drains total_words samples from the SDRAM read FIFO into the USB FIFO as framed packets.
// Define UPLOAD_CHECKSUM_EN to append a 16-bit wrapping payload-sum trailer to every packet.
module sdram_usb_packetizer #(
  parameter int          PKT_WORDS  = 256,
  parameter logic [15:0] HDR_WORD   = 16'hA55A,
  parameter int          FIFO_DEPTH = 2048,
  parameter int          USEDW_W    = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        total_words,
  input  logic               rdfifo_empty,
  output logic               rdfifo_rden,
  input  logic [15:0]        rdfifo_dout,
  input  logic [USEDW_W-1:0] usb_fifo_usedw,
  output logic               usb_fifo_wrreq,
  output logic [15:0]        usb_fifo_wrdata,
  output logic               busy,
  output logic               done
);

`ifdef UPLOAD_CHECKSUM_EN
  localparam int OVH = 4;
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SPACE, S_HDR0, S_HDR1, S_HDR2, S_PAYLOAD, S_TRAILER, S_FIN
  } state_t;
`else
  localparam int OVH = 3;
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SPACE, S_HDR0, S_HDR1, S_HDR2, S_PAYLOAD, S_FIN
  } state_t;
`endif

  state_t      r_state, w_next;
  logic [31:0] r_remaining;
  logic [15:0] r_seq;
  logic [11:0] r_len;
  logic [11:0] r_issued;
  logic [11:0] r_written;
  logic        r_pend;
  logic        r_busy;
  logic        r_done;
`ifdef UPLOAD_CHECKSUM_EN
  logic [15:0] r_sum;
`endif

  logic [11:0] w_len;
  logic        w_space_ok;
  logic        w_rden;
  logic        w_last_wr;
  logic        w_pkt_end;
  logic [31:0] w_rem_next;
  logic        w_wrreq;
  logic [15:0] w_wrdata;

  assign w_len = (r_remaining < 32'(PKT_WORDS)) ? r_remaining[11:0] : 12'(PKT_WORDS);
  // Threshold rearranged as a sum so no term can underflow.
  assign w_space_ok = (32'(usb_fifo_usedw) + 32'(w_len) + 32'(OVH) + 32'd8) <= 32'(FIFO_DEPTH);
  assign w_rden     = (r_state == S_PAYLOAD) && !rdfifo_empty && (r_issued < r_len);
  assign w_last_wr  = (r_state == S_PAYLOAD) && r_pend && (r_written == r_len - 12'd1);
  assign w_rem_next = r_remaining - {20'b0, r_len};
`ifdef UPLOAD_CHECKSUM_EN
  assign w_pkt_end  = (r_state == S_TRAILER);
`else
  assign w_pkt_end  = w_last_wr;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (start) w_next = (total_words == '0) ? S_FIN : S_WAIT_SPACE;
      S_WAIT_SPACE: if (w_space_ok) w_next = S_HDR0;
      S_HDR0:       w_next = S_HDR1;
      S_HDR1:       w_next = S_HDR2;
      S_HDR2:       w_next = S_PAYLOAD;
`ifdef UPLOAD_CHECKSUM_EN
      S_PAYLOAD:    if (w_last_wr) w_next = S_TRAILER;
      S_TRAILER:    w_next = (w_rem_next == '0) ? S_FIN : S_WAIT_SPACE;
`else
      S_PAYLOAD:    if (w_last_wr) w_next = (w_rem_next == '0) ? S_FIN : S_WAIT_SPACE;
`endif
      S_FIN:        w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_wrreq  = 1'b0;
    w_wrdata = '0;
    case (r_state)
      S_HDR0:    begin w_wrreq = 1'b1; w_wrdata = HDR_WORD;        end
      S_HDR1:    begin w_wrreq = 1'b1; w_wrdata = r_seq;           end
      S_HDR2:    begin w_wrreq = 1'b1; w_wrdata = {4'b0, r_len};   end
      S_PAYLOAD: begin
        w_wrreq  = r_pend;
        w_wrdata = r_pend ? rdfifo_dout : '0;
      end
`ifdef UPLOAD_CHECKSUM_EN
      S_TRAILER: begin w_wrreq = 1'b1; w_wrdata = r_sum;           end
`endif
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_seq       <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_written   <= '0;
      r_pend      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_FIN);
      r_pend  <= w_rden;
      if (r_state == S_IDLE && start) begin
        r_remaining <= total_words;
        r_busy      <= 1'b1;
      end
      if (r_state == S_FIN) r_busy <= 1'b0;
      if (r_state == S_WAIT_SPACE) r_len <= w_len;
      if (r_state == S_HDR0) begin
        r_issued  <= '0;
        r_written <= '0;
`ifdef UPLOAD_CHECKSUM_EN
        r_sum     <= '0;
`endif
      end
      if (w_rden) r_issued <= r_issued + 12'd1;
      if (r_pend) begin
        r_written <= r_written + 12'd1;
`ifdef UPLOAD_CHECKSUM_EN
        r_sum     <= r_sum + rdfifo_dout;
`endif
      end
      if (w_pkt_end) begin
        r_seq       <= r_seq + 16'd1;
        r_remaining <= w_rem_next;
      end
    end
  end

  assign rdfifo_rden     = w_rden;
  assign usb_fifo_wrreq  = w_wrreq;
  assign usb_fifo_wrdata = w_wrdata;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule

// File: tb/tb_sdram_usb_packetizer.sv
// Directed bench for sdram_usb_packetizer: table of uploads parsed frame by frame,
// plus hand sequences for zero-length, USB back-pressure, mid-upload reset and checksum.
module tb_sdram_usb_packetizer;
  localparam int FIFO_DEPTH = 2048;
`ifdef UPLOAD_CHECKSUM_EN
  localparam int TB_TRL = 1;
`else
  localparam int TB_TRL = 0;
`endif
  localparam int THR   = FIFO_DEPTH - (256 + 3 + TB_TRL) - 8;
  localparam int LIMIT = 5000;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] total_words;
  logic        rdfifo_empty = 1'b0;
  logic        rdfifo_rden;
  logic [15:0] rdfifo_dout = 16'hDEAD;
  logic [10:0] usb_fifo_usedw;
  logic        usb_fifo_wrreq;
  logic [15:0] usb_fifo_wrdata;
  logic        busy, done;

  sdram_usb_packetizer #(
    .PKT_WORDS(256), .HDR_WORD(16'hA55A), .FIFO_DEPTH(FIFO_DEPTH), .USEDW_W(11)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .total_words(total_words),
    .rdfifo_empty(rdfifo_empty), .rdfifo_rden(rdfifo_rden), .rdfifo_dout(rdfifo_dout),
    .usb_fifo_usedw(usb_fifo_usedw), .usb_fifo_wrreq(usb_fifo_wrreq),
    .usb_fifo_wrdata(usb_fifo_wrdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Read FIFO model: data valid one cycle after rden, garbage otherwise.
  logic [15:0] src_next = '0;
  logic        toggle_mode = 1'b0;
  logic        fixed_mode  = 1'b0;
  always @(posedge clk) begin
    if (rdfifo_rden) begin
      rdfifo_dout <= fixed_mode ? 16'hFFFF : src_next;
      src_next    <= src_next + 16'd1;
    end else begin
      rdfifo_dout <= 16'hDEAD;
    end
    rdfifo_empty <= toggle_mode ? ~rdfifo_empty : 1'b0;
  end

  logic [15:0] wq[$];
  int rd_cnt = 0, done_cnt = 0, rden_when_empty = 0;
  always @(negedge clk) begin
    if (usb_fifo_wrreq) wq.push_back(usb_fifo_wrdata);
    if (rdfifo_rden) rd_cnt++;
    if (rdfifo_rden && rdfifo_empty) rden_when_empty++;
    if (done) done_cnt++;
  end

  int n_pass = 0, n_total = 0;
  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic wait_done(output int cyc, output bit to);
    cyc = 1;
    while (!done && cyc < LIMIT) begin
      @(posedge clk); #1;
      cyc++;
    end
    to = !done;
  endtask

  task automatic run_upload(input logic [31:0] n, output int cyc, output bit to);
    wq.delete(); rd_cnt = 0; done_cnt = 0;
    total_words = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, to);
  endtask

  // Walks the captured write stream; counts every framing or data deviation.
  task automatic parse(input logic [15:0] seq0, input logic [15:0] d0,
                       output int npk, output int lastlen, output int errs);
    int idx, len;
    logic [15:0] s, d, hw;
`ifdef UPLOAD_CHECKSUM_EN
    logic [15:0] sum;
`endif
    idx = 0; s = seq0; d = d0; npk = 0; lastlen = 0; errs = 0;
    while (idx + 3 <= wq.size()) begin
      if (wq[idx] !== 16'hA55A) errs++;
      if (wq[idx+1] !== s) errs++;
      hw = wq[idx+2];
      if (hw[15:12] != 4'd0) errs++;
      len = int'(hw[11:0]);
      if (len == 0 || len > 256) errs++;
      idx += 3;
`ifdef UPLOAD_CHECKSUM_EN
      sum = '0;
`endif
      for (int k = 0; k < len && idx < wq.size(); k++) begin
        if (wq[idx] !== d) errs++;
`ifdef UPLOAD_CHECKSUM_EN
        sum += wq[idx];
`endif
        d++; idx++;
      end
`ifdef UPLOAD_CHECKSUM_EN
      if (idx < wq.size()) begin
        if (wq[idx] !== sum) errs++;
        idx++;
      end else errs++;
`endif
      s++; npk++; lastlen = len;
    end
    if (idx != wq.size()) errs++;
  endtask

  typedef struct {
    logic [31:0] total;
    bit          toggle;
    int          exp_pkts;
    int          exp_last;
    int          exp_writes;
  } vec_t;

  initial begin
    vec_t vec[5];
    int cyc, npk, lastlen, errs;
    bit to;
    logic [15:0] tb_seq, d0;

    vec[0] = '{32'd600, 1'b0, 3, 88,  609};
    vec[1] = '{32'd10,  1'b1, 1, 10,  13};
    vec[2] = '{32'd256, 1'b0, 1, 256, 259};
    vec[3] = '{32'd257, 1'b1, 2, 1,   263};
    vec[4] = '{32'd1,   1'b0, 1, 1,   4};

    reset = 1'b1; start = 1'b0; total_words = '0; usb_fifo_usedw = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_rden",   rdfifo_rden, 0);
    check("rst_wrreq",  usb_fifo_wrreq, 0);
    check("rst_wrdata", usb_fifo_wrdata, 0);
    check("rst_busy",   busy, 0);
    check("rst_done",   done, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    tb_seq = '0;

    for (int i = 0; i < 5; i++) begin
      toggle_mode = vec[i].toggle;
      d0 = src_next;
      run_upload(vec[i].total, cyc, to);
      repeat (2) @(posedge clk); #1;
      check($sformatf("v%0d_timeout", i), to, 0);
      check($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      check($sformatf("v%0d_busy_end", i), busy, 0);
      check($sformatf("v%0d_writes", i), wq.size(), vec[i].exp_writes + TB_TRL * vec[i].exp_pkts);
      check($sformatf("v%0d_reads", i), rd_cnt, vec[i].total);
      parse(tb_seq, d0, npk, lastlen, errs);
      check($sformatf("v%0d_pkts", i), npk, vec[i].exp_pkts);
      check($sformatf("v%0d_lastlen", i), lastlen, vec[i].exp_last);
      check($sformatf("v%0d_frame_errs", i), errs, 0);
      tb_seq += 16'(vec[i].exp_pkts);
    end
    toggle_mode = 1'b0;

    // Zero-length upload; start held into the FIN cycle must be ignored.
    wq.delete(); rd_cnt = 0; done_cnt = 0;
    total_words = '0; start = 1'b1;
    @(posedge clk); #1;
    check("z_busy_c1", busy, 1);
    check("z_done_c1", done, 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("z_done_c2", done, 1);
    check("z_busy_c2", busy, 0);
    @(posedge clk); #1;
    check("z_done_c3", done, 0);
    check("z_busy_c3", busy, 0);
    repeat (3) @(posedge clk); #1;
    check("z_writes", wq.size(), 0);
    check("z_reads", rd_cnt, 0);
    check("z_done_cnt", done_cnt, 1);

    // USB back-pressure at and around the space threshold.
    wq.delete(); rd_cnt = 0; done_cnt = 0;
    d0 = src_next;
    usb_fifo_usedw = 11'd1900;
    total_words = 32'd300; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("bp_no_wr_1900", wq.size(), 0);
    check("bp_busy", busy, 1);
    usb_fifo_usedw = 11'(THR + 1);
    repeat (3) @(posedge clk); #1;
    check("bp_no_wr_thr1", wq.size(), 0);
    usb_fifo_usedw = 11'(THR);
    @(posedge clk); #1;
    check("bp_hdr0_wrreq", usb_fifo_wrreq, 1);
    check("bp_hdr0_data", usb_fifo_wrdata, 16'hA55A);
    wait_done(cyc, to);
    repeat (2) @(posedge clk); #1;
    check("bp_timeout", to, 0);
    check("bp_writes", wq.size(), 306 + 2 * TB_TRL);
    parse(tb_seq, d0, npk, lastlen, errs);
    check("bp_pkts", npk, 2);
    check("bp_lastlen", lastlen, 44);
    check("bp_frame_errs", errs, 0);
    tb_seq += 16'd2;
    usb_fifo_usedw = '0;

`ifdef UPLOAD_CHECKSUM_EN
    fixed_mode = 1'b1;
    run_upload(32'd4, cyc, to);
    repeat (2) @(posedge clk); #1;
    fixed_mode = 1'b0;
    check("ck_timeout", to, 0);
    check("ck_writes", wq.size(), 8);
    check("ck_len", (wq.size() > 2) ? wq[2] : 16'hBAD0, 16'd4);
    check("ck_trailer", (wq.size() > 7) ? wq[7] : 16'hBAD0, 16'hFFFC);
    tb_seq += 16'd1;
`endif

    // Asynchronous reset after 40 payload words of a long upload.
    wq.delete(); rd_cnt = 0; done_cnt = 0;
    total_words = 32'd600; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (wq.size() < 43 && cyc < LIMIT) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ar_reach_40", wq.size() >= 43, 1);
    reset = 1'b1;
    #1;
    check("ar_rden_low", rdfifo_rden, 0);
    check("ar_wrreq_low", usb_fifo_wrreq, 0);
    check("ar_busy_low", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    tb_seq = '0;
    d0 = src_next;
    run_upload(32'd5, cyc, to);
    repeat (2) @(posedge clk); #1;
    check("ar_timeout", to, 0);
    check("ar_writes", wq.size(), 8 + TB_TRL);
    parse(tb_seq, d0, npk, lastlen, errs);
    check("ar_pkts", npk, 1);
    check("ar_frame_errs", errs, 0);
    check("ar_seq0", (wq.size() > 1) ? wq[1] : 16'hBAD0, 16'd0);

    check("rden_when_empty", rden_when_empty, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
